// File: rtl/t07_mmio_responder_if.sv
// CPU-side MMIO request signals and the Wishbone-classic master signals of the responder.
// "slave" is the responder's view; "master" is the view of whatever drives requests and the bus.
interface t07_mmio_responder_if;
  logic [1:0]  rwi_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  wsize_i;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport slave (
    input  rwi_i, addr_i, wdata_i, wsize_i, wb_dat_i, wb_ack_i,
    output busy_o, rdata_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport master (
    output rwi_i, addr_i, wdata_i, wsize_i, wb_dat_i, wb_ack_i,
    input  busy_o, rdata_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/t07_mmio_responder.sv
// MMIO responder: turns one CPU fetch/load/store request into a single Wishbone-classic cycle,
// with byte-lane alignment, misalignment rejection and an ack timeout.
module t07_mmio_responder #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hBAD0_BAD0
) (
  input  logic                   clk,
  input  logic                   nrst,
  t07_mmio_responder_if.slave    bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_MIS  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic              r_rd, w_rd_nxt;
  logic [1:0]        r_ofs, w_ofs_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic              r_cyc, w_cyc_nxt;
  logic              r_we, w_we_nxt;
  logic [31:0]       r_adr, w_adr_nxt;
  logic [31:0]       r_dat, w_dat_nxt;
  logic [3:0]        r_sel, w_sel_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;

  logic              w_req;
  logic              w_wr;
  logic              w_misal;
  logic              w_ack;
  logic              w_tmo;

  function automatic logic misaligned(input logic [1:0] rwi, input logic [1:0] size,
                                      input logic [1:0] ofs);
    logic m;
    m = 1'b0;
    if (rwi == 2'b11) begin
      m = (ofs != 2'b00);
    end else if (rwi == 2'b01) begin
      case (size)
        2'b00:   m = 1'b0;
        2'b01:   m = ofs[0];
        default: m = (ofs != 2'b00);
      endcase
    end
    return m;
  endfunction

  // Reads always fetch the whole word; the lane shift happens on the way back.
  function automatic logic [3:0] lane_sel(input logic wr, input logic [1:0] size,
                                          input logic [1:0] ofs);
    logic [3:0] s;
    s = 4'hF;
    if (wr) begin
      case (size)
        2'b00:   s = 4'b0001 << ofs;
        2'b01:   s = 4'b0011 << ofs;
        default: s = 4'hF;
      endcase
    end
    return s;
  endfunction

  assign w_req   = (bus.rwi_i != 2'b00);
  assign w_wr    = (bus.rwi_i == 2'b01);
  assign w_misal = misaligned(bus.rwi_i, bus.wsize_i, bus.addr_i[1:0]);
  assign w_ack   = bus.wb_ack_i;
  assign w_tmo   = !w_ack && (r_tcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = w_misal ? S_MIS : S_REQ;
      S_REQ:   if (w_ack || w_tmo) w_state_nxt = S_HOLD;
      S_MIS:   w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_tcnt_nxt  = r_tcnt;
    w_rd_nxt    = r_rd;
    w_ofs_nxt   = r_ofs;
    w_busy_nxt  = r_busy;
    w_err_nxt   = 1'b0;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_adr_nxt   = r_adr;
    w_dat_nxt   = r_dat;
    w_sel_nxt   = r_sel;
    w_rdata_nxt = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_busy_nxt = 1'b1;
          w_rd_nxt   = bus.rwi_i[1];
          w_ofs_nxt  = bus.addr_i[1:0];
          w_tcnt_nxt = '0;
          if (!w_misal) begin
            w_cyc_nxt = 1'b1;
            w_we_nxt  = w_wr;
            w_adr_nxt = {bus.addr_i[31:2], 2'b00};
            w_sel_nxt = lane_sel(w_wr, bus.wsize_i, bus.addr_i[1:0]);
            if (w_wr) w_dat_nxt = bus.wdata_i << {bus.addr_i[1:0], 3'b000};
          end
        end
      end
      S_REQ: begin
        if (w_ack || w_tmo) begin
          w_cyc_nxt  = 1'b0;
          w_we_nxt   = 1'b0;
          w_busy_nxt = 1'b0;
          w_err_nxt  = w_tmo;
          if (r_rd) w_rdata_nxt = w_ack ? (bus.wb_dat_i >> {r_ofs, 3'b000}) : ERR_DATA;
        end else begin
          w_tcnt_nxt = r_tcnt + CNT_W'(1);
        end
      end
      S_MIS: begin
        w_busy_nxt = 1'b0;
        w_err_nxt  = 1'b1;
        if (r_rd) w_rdata_nxt = ERR_DATA;
      end
      default: ;
    endcase
  end

  // Registered outputs; reset kills an in-flight bus cycle without reporting completion.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tcnt  <= '0;
      r_rd    <= 1'b0;
      r_ofs   <= 2'b00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= 4'h0;
      r_rdata <= '0;
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_rd    <= w_rd_nxt;
      r_ofs   <= w_ofs_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
      r_sel   <= w_sel_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign bus.busy_o   = r_busy;
  assign bus.err_o    = r_err;
  assign bus.rdata_o  = r_rdata;
  assign bus.wb_cyc_o = r_cyc;
  assign bus.wb_stb_o = r_cyc;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_dat;
  assign bus.wb_sel_o = r_sel;

endmodule
